// File: rtl/lumos_mem_pkg.sv
// Shared load/store codes and the bridge state type for the LSU bus bridge.
// The load code normaliser folds the unused MemRead encodings onto lw.
package lumos_mem_pkg;

    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_SB   = 2'b01;
    localparam logic [1:0] MW_SH   = 2'b10;
    localparam logic [1:0] MW_SW   = 2'b11;

    localparam logic [2:0] MR_LW   = 3'b000;
    localparam logic [2:0] MR_LB   = 3'b001;
    localparam logic [2:0] MR_LH   = 3'b010;
    localparam logic [2:0] MR_LBU  = 3'b011;
    localparam logic [2:0] MR_LHU  = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        DONE
    } lsu_state_t;

    function automatic logic [2:0] norm_load_code(input logic [2:0] mr);
        return (mr > MR_LHU) ? MR_LW : mr;
    endfunction

endpackage

// File: rtl/lsu_bus_bridge_if.sv
// Word-aligned valid/ready memory bus between the LSU bridge (master) and memory (slave).
// Stores are posted; only loads produce a response.
interface lsu_bus_bridge_if #(
    parameter int ADDR_W = 32
) ();

    logic              bus_req_valid;
    logic              bus_req_ready;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_wstrb;
    logic [31:0]       bus_wdata;
    logic              bus_rsp_valid;
    logic [31:0]       bus_rsp_data;

    modport master (
        output bus_req_valid,
        output bus_we,
        output bus_addr,
        output bus_wstrb,
        output bus_wdata,
        input  bus_req_ready,
        input  bus_rsp_valid,
        input  bus_rsp_data
    );

    modport slave (
        input  bus_req_valid,
        input  bus_we,
        input  bus_addr,
        input  bus_wstrb,
        input  bus_wdata,
        output bus_req_ready,
        output bus_rsp_valid,
        output bus_rsp_data
    );

endinterface

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a bus word and sign/zero-extends it
// according to the load code; lw and any unknown code pass the word through.
module lsu_load_align
    import lumos_mem_pkg::*;
(
    input  logic [2:0]  code_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] word_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Halves are only ever issued at lane 0 or 2, so lane bit 1 selects them.
    always_comb begin
        case (lane_i)
            2'd0:    byte_v = word_i[7:0];
            2'd1:    byte_v = word_i[15:8];
            2'd2:    byte_v = word_i[23:16];
            default: byte_v = word_i[31:24];
        endcase
        half_v = lane_i[1] ? word_i[31:16] : word_i[15:0];

        case (code_i)
            MR_LB:   result_o = {{24{byte_v[7]}}, byte_v};
            MR_LH:   result_o = {{16{half_v[15]}}, half_v};
            MR_LBU:  result_o = {24'd0, byte_v};
            MR_LHU:  result_o = {16'd0, half_v};
            default: result_o = word_i;
        endcase
    end

endmodule

// File: rtl/lsu_bus_bridge.sv
// Turns one core load/store into a single word-aligned bus transaction, stalling
// the core until it completes, and returns the formatted load result.
module lsu_bus_bridge
    import lumos_mem_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    input  logic              ld_en_i,
    input  logic [1:0]        mem_write_i,
    input  logic [2:0]        mem_read_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              stall_o,
    output logic [31:0]       rdata_o,
    output logic              rdata_valid_o,
    output logic              misalign_o,
    output logic              bus_timeout_o,
    lsu_bus_bridge_if.master  bus
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    lsu_state_t        state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        code_q, code_d;
    logic [1:0]        lane_q, lane_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic              misalign_q, misalign_d;
    logic              timeout_q, timeout_d;

    logic              is_store;
    logic              start;
    logic [2:0]        ld_code;
    logic [1:0]        lane;
    logic              misaligned;
    logic [3:0]        new_strb;
    logic [31:0]       new_wdata;
    logic [31:0]       load_result;

    lsu_load_align u_align (
        .code_i   (code_q),
        .lane_i   (lane_q),
        .word_i   (bus.bus_rsp_data),
        .result_o (load_result)
    );

    // Decode the incoming request; a store takes priority over ld_en.
    always_comb begin
        is_store   = (mem_write_i != MW_NONE);
        start      = req_valid_i & (ld_en_i | is_store);
        ld_code    = norm_load_code(mem_read_i);
        lane       = addr_i[1:0];
        misaligned = 1'b0;
        new_strb   = 4'b0000;
        new_wdata  = 32'd0;
        if (is_store) begin
            case (mem_write_i)
                MW_SB: begin
                    new_strb  = 4'b0001 << lane;
                    new_wdata = {4{wdata_i[7:0]}};
                end
                MW_SH: begin
                    misaligned = lane[0];
                    new_strb   = 4'b0011 << lane;
                    new_wdata  = {2{wdata_i[15:0]}};
                end
                MW_SW: begin
                    misaligned = (lane != 2'b00);
                    new_strb   = 4'b1111;
                    new_wdata  = wdata_i;
                end
                default: ;
            endcase
        end else begin
            case (ld_code)
                MR_LH, MR_LHU: misaligned = lane[0];
                MR_LW:         misaligned = (lane != 2'b00);
                default:       misaligned = 1'b0;
            endcase
        end
        stall_o = (state_q == REQ) | (state_q == WAIT_RSP) | ((state_q == IDLE) & start);
    end

    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wstrb_d       = wstrb_q;
        wdata_d       = wdata_q;
        code_d        = code_q;
        lane_d        = lane_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        misalign_d    = 1'b0;
        timeout_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (misaligned) begin
                        misalign_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        we_d    = is_store;
                        addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
                        wstrb_d = new_strb;
                        wdata_d = new_wdata;
                        code_d  = ld_code;
                        lane_d  = lane;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.bus_req_ready) begin
                    cnt_d   = '0;
                    state_d = we_q ? DONE : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                // A response arriving on the timeout cycle still wins.
                if (bus.bus_rsp_valid) begin
                    rdata_d       = load_result;
                    rdata_valid_d = 1'b1;
                    state_d       = DONE;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    rdata_d   = 32'd0;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wstrb_q       <= 4'b0000;
            wdata_q       <= 32'd0;
            code_q        <= MR_LW;
            lane_q        <= 2'b00;
            cnt_q         <= '0;
            rdata_q       <= 32'd0;
            rdata_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wstrb_q       <= wstrb_d;
            wdata_q       <= wdata_d;
            code_q        <= code_d;
            lane_q        <= lane_d;
            cnt_q         <= cnt_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            misalign_q    <= misalign_d;
            timeout_q     <= timeout_d;
        end
    end

    assign bus.bus_req_valid = (state_q == REQ);
    assign bus.bus_we        = we_q;
    assign bus.bus_addr      = addr_q;
    assign bus.bus_wstrb     = wstrb_q;
    assign bus.bus_wdata     = wdata_q;

    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign misalign_o    = misalign_q;
    assign bus_timeout_o = timeout_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Bench for lsu_bus_bridge: directed cases then randomized accesses against a
// behavioural model of lane strobes, replication, load extension and latency.
module tb_lsu_bus_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reqValid;
    logic        ldEn;
    logic [1:0]  memWrite;
    logic [2:0]  memRead;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdataValid;
    logic        misalign;
    logic        busTimeout;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] expRdata = 32'd0;

    always #5 clk = ~clk;

    lsu_bus_bridge_if #(.ADDR_W(32)) busIf ();

    lsu_bus_bridge #(
        .ADDR_W         (32),
        .TIMEOUT_CYCLES (256)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (reqValid),
        .ld_en_i       (ldEn),
        .mem_write_i   (memWrite),
        .mem_read_i    (memRead),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .stall_o       (stall),
        .rdata_o       (rdata),
        .rdata_valid_o (rdataValid),
        .misalign_o    (misalign),
        .bus_timeout_o (busTimeout),
        .bus           (busIf)
    );

    function automatic int accessSize(input logic [1:0] mw, input logic [2:0] mr);
        if (mw == 2'd1) return 1;
        if (mw == 2'd2) return 2;
        if (mw == 2'd3) return 4;
        if (mr == 3'd1 || mr == 3'd3) return 1;
        if (mr == 3'd2 || mr == 3'd4) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] loadModel(input logic [2:0] mr, input int lane, input logic [31:0] word);
        logic [31:0] shifted;
        shifted = word >> (8 * lane);
        case (mr)
            3'd1:    return 32'($signed(shifted[7:0]));
            3'd2:    return 32'($signed(shifted[15:0]));
            3'd3:    return shifted & 32'h0000_00FF;
            3'd4:    return shifted & 32'h0000_FFFF;
            default: return word;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One core access with a slave that waits readyDelay REQ cycles and answers
    // loads after rspDelay WAIT cycles (negative: never answers).
    task automatic applyStimulus(input logic ldE, input logic [1:0] mw, input logic [2:0] mr,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input int readyDelay, input int rspDelay, input logic [31:0] rspWord);
        logic        isStore, isLoad, mis, timedOut, done, reqSeen, unstable, strayPulse, waiting;
        int          size, lane, stallCnt, expStall, reqCnt, waitCnt;
        logic        snapWe;
        logic [31:0] snapAddr, snapWdata, expWdata;
        logic [3:0]  snapStrb, expStrb;
        logic [2:0]  code;
        isStore    = (mw != 2'd0);
        isLoad     = !isStore && ldE;
        code       = (mr > 3'd4) ? 3'd0 : mr;
        size       = accessSize(mw, isStore ? 3'd0 : code);
        lane       = int'(a[1:0]);
        mis        = (isStore || isLoad) && ((lane % size) != 0);
        timedOut   = isLoad && !mis && (rspDelay < 0);
        expStrb    = 4'(((1 << size) - 1) << lane);
        expWdata   = (size == 1) ? wd[7:0] * 32'h0101_0101 :
                     (size == 2) ? wd[15:0] * 32'h0001_0001 : wd;
        if (!(isStore || isLoad)) expStall = 0;
        else if (mis)             expStall = 1;
        else if (isStore)         expStall = 2 + readyDelay;
        else                      expStall = 2 + readyDelay + (timedOut ? 256 : rspDelay + 1);
        done = 0; reqSeen = 0; unstable = 0; strayPulse = 0; waiting = 0;
        stallCnt = 0; reqCnt = 0; waitCnt = 0;
        snapWe = 0; snapAddr = 0; snapWdata = 0; snapStrb = 0;

        @(posedge clk); #1;
        reqValid = 1'b1; ldEn = ldE; memWrite = mw; memRead = mr; addr = a; wdata = wd;

        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1;
                reqValid = 1'b0;
                busIf.bus_req_ready = 1'($urandom % 2);
                busIf.bus_rsp_valid = 1'($urandom % 2);
                busIf.bus_rsp_data  = $urandom;
            end else begin
                stallCnt++;
                if (rdataValid || misalign || busTimeout) strayPulse = 1;
                if (busIf.bus_req_valid) begin
                    if (!reqSeen) begin
                        snapWe = busIf.bus_we; snapAddr = busIf.bus_addr;
                        snapStrb = busIf.bus_wstrb; snapWdata = busIf.bus_wdata;
                    end else if (snapWe !== busIf.bus_we || snapAddr !== busIf.bus_addr ||
                                 snapStrb !== busIf.bus_wstrb || snapWdata !== busIf.bus_wdata) begin
                        unstable = 1;
                    end
                    reqSeen = 1;
                end
                if (waiting) begin
                    busIf.bus_rsp_valid = (waitCnt == rspDelay);
                    busIf.bus_rsp_data  = (waitCnt == rspDelay) ? rspWord : $urandom;
                    waitCnt++;
                end else begin
                    busIf.bus_rsp_valid = 1'($urandom % 2);
                    busIf.bus_rsp_data  = $urandom;
                end
                if (busIf.bus_req_valid) begin
                    busIf.bus_req_ready = (reqCnt >= readyDelay);
                    if (busIf.bus_req_ready && isLoad) begin
                        waiting = 1;
                        waitCnt = 0;
                    end
                    reqCnt++;
                end else begin
                    busIf.bus_req_ready = 1'($urandom % 2);
                end
            end
        end

        checkOutput("cycle_budget", 32'(done), 32'd1);
        if (!done) return;
        if (isLoad && !mis) expRdata = timedOut ? 32'd0 : loadModel(code, lane, rspWord);
        checkOutput("stall_cycles", 32'(stallCnt), 32'(expStall));
        checkOutput("misalign", 32'(misalign), 32'(mis));
        checkOutput("rdata_valid", 32'(rdataValid), 32'(isLoad && !mis && !timedOut));
        checkOutput("bus_timeout", 32'(busTimeout), 32'(timedOut));
        checkOutput("rdata", rdata, expRdata);
        checkOutput("no_early_pulse", 32'(strayPulse), 32'd0);
        if ((isStore || isLoad) && !mis) begin
            checkOutput("bus_req_seen", 32'(reqSeen), 32'd1);
            checkOutput("bus_we", 32'(snapWe), 32'(isStore));
            checkOutput("bus_addr", snapAddr, a & ~32'd3);
            checkOutput("bus_wstrb", 32'(snapStrb), isStore ? 32'(expStrb) : 32'd0);
            if (isStore) checkOutput("bus_wdata", snapWdata, expWdata);
            checkOutput("bus_stable", 32'(unstable), 32'd0);
        end else if (mis) begin
            checkOutput("no_bus_req", 32'(reqSeen), 32'd0);
        end

        @(negedge clk);
        checkOutput("pulse_width", {29'd0, rdataValid, misalign, busTimeout}, 32'd0);
        checkOutput("idle_stall", 32'(stall), 32'd0);
        checkOutput("rdata_hold", rdata, expRdata);
    endtask

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; reqValid = 1'b0; ldEn = 1'b0; memWrite = 2'd0; memRead = 3'd0;
        addr = 32'd0; wdata = 32'd0;
        busIf.bus_req_ready = 1'b1; busIf.bus_rsp_valid = 1'b1; busIf.bus_rsp_data = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("[TB] checking reset state");
        checkOutput("reset_stall", 32'(stall), 32'd0);
        checkOutput("reset_rdata", rdata, 32'd0);
        checkOutput("reset_pulses", {29'd0, rdataValid, misalign, busTimeout}, 32'd0);
        checkOutput("reset_bus_req_valid", 32'(busIf.bus_req_valid), 32'd0);
        checkOutput("reset_bus_wstrb", 32'(busIf.bus_wstrb), 32'd0);
        checkOutput("reset_bus_addr", busIf.bus_addr, 32'd0);
        busIf.bus_rsp_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("[TB] directed accesses");
        applyStimulus(1'b0, 2'd3, 3'd0, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 32'd0);
        applyStimulus(1'b0, 2'd1, 3'd0, 32'h0000_0103, 32'h0000_00A5, 0, 0, 32'd0);
        applyStimulus(1'b1, 2'd0, 3'd1, 32'h0000_0202, 32'd0, 0, 4, 32'h1280_FF00);
        applyStimulus(1'b1, 2'd0, 3'd3, 32'h0000_0202, 32'd0, 1, 2, 32'h1280_FF00);
        applyStimulus(1'b1, 2'd0, 3'd2, 32'h0000_0201, 32'd0, 0, 0, 32'd0);
        applyStimulus(1'b1, 2'd2, 3'd0, 32'h0000_0042, 32'h1234_BEEF, 2, 0, 32'd0);
        applyStimulus(1'b1, 2'd0, 3'd6, 32'h0000_0404, 32'd0, 0, 0, 32'hCAFE_F00D);
        applyStimulus(1'b1, 2'd0, 3'd4, 32'h0000_0406, 32'd0, 0, 1, 32'h8001_7FFE);
        applyStimulus(1'b0, 2'd0, 3'd0, 32'h0000_0500, 32'd0, 0, 0, 32'd0);
        applyStimulus(1'b1, 2'd0, 3'd0, 32'h0000_0600, 32'd0, 5, -1, 32'd0);

        $display("[TB] reset during WAIT_RSP");
        @(posedge clk); #1;
        reqValid = 1'b1; ldEn = 1'b1; memWrite = 2'd0; memRead = 3'd0; addr = 32'h0000_0300;
        busIf.bus_req_ready = 1'b1; busIf.bus_rsp_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_wait_stall", 32'(stall), 32'd1);
        rst_n = 1'b0; reqValid = 1'b0; busIf.bus_req_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        busIf.bus_rsp_valid = 1'b1; busIf.bus_rsp_data = 32'h55AA_55AA;
        checkOutput("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        busIf.bus_rsp_valid = 1'b0;
        expRdata = 32'd0;
        checkOutput("rst_stray_stall", 32'(stall), 32'd0);
        checkOutput("rst_stray_rdata_valid", 32'(rdataValid), 32'd0);
        checkOutput("rst_stray_rdata", rdata, expRdata);
        checkOutput("rst_stray_bus_req", 32'(busIf.bus_req_valid), 32'd0);

        $display("[TB] randomized accesses");
        for (int n = 0; n < 40; n++) begin
            logic [1:0]  mw;
            logic [2:0]  mr;
            logic        le;
            logic [31:0] a;
            int          sz;
            mw = ($urandom % 2 == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            le = ($urandom % 8 != 0);
            mr = 3'($urandom_range(0, 7));
            a  = $urandom;
            sz = accessSize(mw, (mr > 3'd4) ? 3'd0 : mr);
            if ($urandom % 5 != 0) a = a & ~32'(sz - 1);
            applyStimulus(le, mw, mr, a, $urandom, $urandom_range(0, 4), $urandom_range(0, 6), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
